// File: rtl/gen_counter_if.sv
// Counter control/status bundle: enable, load, mode in; count, terminal-count, saturate out.
// Pure wiring, no latency of its own.
// No backpressure: the counter consumes en/load on every edge it sees them.
interface gen_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             sat;

  modport master (output en, load, load_val, mode, input cnt, tc, sat);
  modport slave  (input en, load, load_val, mode, output cnt, tc, sat);
endinterface

// File: rtl/gen_counter.sv
// Prescaled up/down counter with wrap or saturate modes, clamped load and terminal-count pulse.
// Latency: cnt/tc/sat are registered, one clock after the edge that samples the cause.
// No backpressure: en/load are accepted on every edge; init overrides load, load overrides step.
module gen_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               PRESCALE = 1
) (
  input  logic          clk,
  input  logic          init,
  gen_counter_if.slave  bus
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_q, pre_nxt;
  logic [WIDTH-1:0] cnt_q, cnt_nxt;
  logic             tc_q, tc_nxt;
  logic             sat_q, sat_nxt;

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.sat = sat_q;

  // Next-state: load beats a count step; tc is a pulse so it defaults low every cycle.
  always_comb begin
    cnt_nxt = cnt_q;
    pre_nxt = pre_q;
    tc_nxt  = 1'b0;
    sat_nxt = sat_q;
    if (bus.load) begin
      cnt_nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
      pre_nxt = '0;
      sat_nxt = 1'b0;
    end else if (bus.en) begin
      if (pre_q == PRE_LAST) begin
        pre_nxt = '0;
        // A step that moves cnt always clears sat; only a blocked saturating step sets it.
        sat_nxt = 1'b0;
        case (bus.mode)
          2'b00: begin
            if (cnt_q == MAX) begin
              cnt_nxt = '0;
              tc_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_q + 1'b1;
            end
          end
          2'b01: begin
            if (cnt_q == '0) begin
              cnt_nxt = MAX;
              tc_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_q - 1'b1;
            end
          end
          2'b10: begin
            if (cnt_q < MAX) cnt_nxt = cnt_q + 1'b1;
            else             sat_nxt = 1'b1;
          end
          default: begin
            if (cnt_q != '0) cnt_nxt = cnt_q - 1'b1;
            else             sat_nxt = 1'b1;
          end
        endcase
      end else begin
        pre_nxt = pre_q + 1'b1;
      end
    end
  end

  // State register with synchronous init taking priority over everything else.
  always_ff @(posedge clk) begin
    if (init) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      pre_q <= pre_nxt;
      tc_q  <= tc_nxt;
      sat_q <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_gen_counter.sv
// Bench for gen_counter: PRESCALE=1 and PRESCALE=3 instances (WIDTH=4, MAX=9) share stimulus.
// A behavioural model tracks both; directed sequences pin known values, then random traffic.
// Outputs are compared on every falling edge once the first init has been applied.
module tb_gen_counter;

  localparam int MAXV = 9;

  logic       clk;
  logic       init;
  logic       en;
  logic       load;
  logic [1:0] mode;
  logic [3:0] load_val;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  gen_counter_if #(.WIDTH(4)) if1 ();
  gen_counter_if #(.WIDTH(4)) if3 ();

  assign if1.en = en;  assign if1.load = load;  assign if1.mode = mode;  assign if1.load_val = load_val;
  assign if3.en = en;  assign if3.load = load;  assign if3.mode = mode;  assign if3.load_val = load_val;

  gen_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(1)) dut1 (.clk(clk), .init(init), .bus(if1));
  gen_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(3)) dut3 (.clk(clk), .init(init), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model, index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
  int m_cnt [2];
  int m_pre [2];
  int m_tc  [2];
  int m_sat [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int ps;
      ps = (k == 0) ? 1 : 3;
      if (init) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_sat[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        m_pre[k] = 0; m_tc[k] = 0; m_sat[k] = 0;
      end else begin
        m_tc[k] = 0;
        if (en) begin
          if (m_pre[k] == ps - 1) begin
            m_pre[k] = 0;
            case (mode)
              2'd0: begin
                m_tc[k]  = (m_cnt[k] == MAXV) ? 1 : 0;
                m_cnt[k] = (m_cnt[k] + 1) % (MAXV + 1);
                m_sat[k] = 0;
              end
              2'd1: begin
                m_tc[k]  = (m_cnt[k] == 0) ? 1 : 0;
                m_cnt[k] = (m_cnt[k] + MAXV) % (MAXV + 1);
                m_sat[k] = 0;
              end
              2'd2: begin
                if (m_cnt[k] == MAXV) m_sat[k] = 1;
                else begin m_cnt[k] = m_cnt[k] + 1; m_sat[k] = 0; end
              end
              default: begin
                if (m_cnt[k] == 0) m_sat[k] = 1;
                else begin m_cnt[k] = m_cnt[k] - 1; m_sat[k] = 0; end
              end
            endcase
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model cnt p1", int'(if1.cnt), m_cnt[0]);
      chk("model tc p1",  int'(if1.tc),  m_tc[0]);
      chk("model sat p1", int'(if1.sat), m_sat[0]);
      chk("model cnt p3", int'(if3.cnt), m_cnt[1]);
      chk("model tc p3",  int'(if3.tc),  m_tc[1]);
      chk("model sat p3", int'(if3.sat), m_sat[1]);
    end
  end

  // Apply one set of inputs across one rising edge; returns 1 time unit after the edge.
  task automatic edge_in(input logic i_init, input logic i_en, input logic i_load,
                         input logic [1:0] i_mode, input logic [3:0] i_lv);
    init = i_init; en = i_en; load = i_load; mode = i_mode; load_val = i_lv;
    @(posedge clk);
    #1;
  endtask

  int wrap_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int sd_cnt   [4]  = '{1, 0, 0, 0};
  int sd_sat   [4]  = '{0, 0, 1, 1};
  int ps9_exp  [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  int gap_en   [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int gap_exp  [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    logic [1:0] rmode;
    init = 1'b0; en = 1'b0; load = 1'b0; mode = 2'b00; load_val = 4'd0;

    // Reset state.
    edge_in(1'b1, 1'b1, 1'b1, 2'b00, 4'd7);
    chk_on = 1'b1;
    chk("reset cnt", int'(if1.cnt), 0);
    chk("reset tc",  int'(if1.tc),  0);
    chk("reset sat", int'(if1.sat), 0);
    chk("reset cnt p3", int'(if3.cnt), 0);

    // Wrap-up for 12 edges.
    for (int i = 0; i < 12; i++) begin
      edge_in(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
      chk($sformatf("wrap cnt[%0d]", i), int'(if1.cnt), wrap_exp[i]);
      chk($sformatf("wrap tc[%0d]", i),  int'(if1.tc),  (i == 9) ? 1 : 0);
    end

    // Saturate-down from a load of 2.
    edge_in(1'b0, 1'b1, 1'b1, 2'b11, 4'd2);
    chk("sd load cnt", int'(if1.cnt), 2);
    for (int i = 0; i < 4; i++) begin
      edge_in(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
      chk($sformatf("sd cnt[%0d]", i), int'(if1.cnt), sd_cnt[i]);
      chk($sformatf("sd sat[%0d]", i), int'(if1.sat), sd_sat[i]);
      chk($sformatf("sd tc[%0d]", i),  int'(if1.tc),  0);
    end

    // Load clamp and init-over-load priority.
    edge_in(1'b0, 1'b1, 1'b1, 2'b00, 4'd15);
    chk("clamp cnt", int'(if1.cnt), 9);
    chk("clamp sat", int'(if1.sat), 0);
    edge_in(1'b1, 1'b1, 1'b1, 2'b00, 4'd15);
    chk("init beats load", int'(if1.cnt), 0);

    // Prescaler 3: steps on edges 3, 6, 9.
    edge_in(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 9; i++) begin
      edge_in(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
      chk($sformatf("ps cnt[%0d]", i), int'(if3.cnt), ps9_exp[i]);
    end

    // Prescaler with two disabled edges mid-run.
    edge_in(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 11; i++) begin
      edge_in(1'b0, gap_en[i] != 0, 1'b0, 2'b00, 4'd0);
      chk($sformatf("gap cnt[%0d]", i), int'(if3.cnt), gap_exp[i]);
    end

    // Mid-run init at cnt=5, pre=1: prescaler restarts.
    edge_in(1'b0, 1'b1, 1'b1, 2'b00, 4'd5);
    edge_in(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
    chk("mid cnt before init", int'(if3.cnt), 5);
    edge_in(1'b1, 1'b1, 1'b0, 2'b00, 4'd0);
    chk("mid init cnt", int'(if3.cnt), 0);
    for (int i = 0; i < 3; i++) begin
      edge_in(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
      chk($sformatf("mid resume cnt[%0d]", i), int'(if3.cnt), (i == 2) ? 1 : 0);
    end

    // Saturated at 9 in saturate-up, then one wrap-down step.
    edge_in(1'b0, 1'b1, 1'b1, 2'b10, 4'd9);
    edge_in(1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
    chk("limit sat", int'(if1.sat), 1);
    chk("limit cnt", int'(if1.cnt), 9);
    edge_in(1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
    chk("switch cnt", int'(if1.cnt), 8);
    chk("switch sat", int'(if1.sat), 0);
    chk("switch tc",  int'(if1.tc),  0);

    // Random traffic; modes persist for a while so limits and wraps are reached.
    rmode = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
      edge_in($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, rmode, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_counter.md
GEN_COUNTER -- requirements
Module: gen_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal 1..32).
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1, highest count value (legal 1..2**WIDTH-1).
REQ-003 SHALL have parameter PRESCALE, default 1, enabled cycles per count step (legal >=1).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port init, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1, count enable; advances the prescaler when high.
REQ-007 SHALL have port load, input, 1, synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH, value to load.
REQ-009 SHALL have port mode, input, 2: 00 wrap-up, 01 wrap-down, 10 saturate-up, 11 saturate-down.
REQ-010 SHALL have port cnt, output, WIDTH, registered count value.
REQ-011 SHALL have port tc, output, 1, registered one-cycle terminal-count pulse on wrap.
REQ-012 SHALL have port sat, output, 1, registered level; high while held at a saturation limit.

Function
REQ-013 SHALL apply priority per edge: init > load > count step > hold.
REQ-014 SHALL keep an internal prescaler pre in 0..PRESCALE-1; en high and pre==PRESCALE-1 -> step and pre=0; en high otherwise -> pre+1; en low -> pre held.
REQ-015 SHALL, with PRESCALE=1, step on every edge with en high (pre constant 0).
REQ-016 SHALL, on load, set cnt=min(load_val, MAX), pre=0, tc=0, sat=0; load ignores en.
REQ-017 SHALL, on step in mode 00, set cnt=cnt+1, or cnt=0 with tc=1 when cnt==MAX.
REQ-018 SHALL, on step in mode 01, set cnt=cnt-1, or cnt=MAX with tc=1 when cnt==0.
REQ-019 SHALL, on step in mode 10, set cnt=cnt+1 if cnt<MAX, else hold cnt and set sat=1.
REQ-020 SHALL, on step in mode 11, set cnt=cnt-1 if cnt>0, else hold cnt and set sat=1.
REQ-021 SHALL drive tc high for exactly the one cycle in which cnt shows the wrapped value; tc=0 in every other cycle, including back-to-back steps that do not wrap.
REQ-022 SHALL clear sat on any step that changes cnt, on load, and on init; sat never asserts in modes 00/01.
REQ-023 SHALL sample mode at each step; a mode change takes effect on the next step with no extra latency and does not reset pre.
REQ-024 SHALL keep cnt within 0..MAX at all times; no arithmetic overflow outside WIDTH bits.
REQ-025 SHALL give cnt/tc/sat a latency of one clock from the edge that samples the causing input.

Reset
REQ-026 SHALL, while init is high at a rising edge, set cnt=0, pre=0, tc=0, sat=0, overriding load and en.
REQ-027 SHALL resume counting from 0 on the first edge after init deasserts, with prescaler restarted.
REQ-028 SHALL have no asynchronous behaviour; init pulses not spanning a rising edge have no effect.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-029 SHALL verify wrap-up: init, mode=00, en=1 for 12 edges -> cnt 1..9,0,1,2; tc=1 only in cycle cnt=0.
REQ-030 SHALL verify saturate-down: load_val=2, mode=11, en=1 for 4 edges -> cnt 1,0,0,0; sat=0,0,1,1; tc always 0.
REQ-031 SHALL verify load clamp and priority: load_val=15, load=1, en=1 -> cnt=9; init=1 with load=1 same edge -> cnt=0.
REQ-032 SHALL verify prescaler: PRESCALE=3, mode=00, en=1 for 9 edges -> cnt steps on edges 3,6,9 only; en low 2 edges mid-run delays steps by 2.
REQ-033 SHALL verify mid-run reset: counting at cnt=5 with pre=1 (PRESCALE=3), init one edge -> cnt=0, next step after 3 enabled edges.
REQ-034 SHALL verify mode switch at limit: saturated at cnt=9 mode=10, switch to mode=01, one step -> cnt=8, sat=0.
